// File: rtl/rs485_poll_pkg.sv
// Shared constants and FSM state encodings for the RS485 two-channel poll scheduler.
package rs485_poll_pkg;

  localparam int unsigned IDX_W         = 5;
  localparam int unsigned TO_W          = 16;
  localparam int unsigned PKT_BYTES_DEF = 20;
  localparam logic [7:0]  REQ_CODE_DEF  = 8'hA5;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_TX_SETUP = 3'd1;
  localparam state_t ST_TX_SEND  = 3'd2;
  localparam state_t ST_TX_HOLD  = 3'd3;
  localparam state_t ST_RX_WAIT  = 3'd4;
  localparam state_t ST_DONE     = 3'd5;

endpackage

// File: rtl/rs485_poll_sched_if.sv
// UART core, frame buffer and packet status bus of the poll scheduler.
// pkt_cks_err exists only when POLL_CHECKSUM_EN is defined.
interface rs485_poll_sched_if;
  import rs485_poll_pkg::*;

  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy;
  logic [1:0]       rx_valid;
  logic [15:0]      rx_data;
  logic             buf_we;
  logic [IDX_W:0]   buf_addr;
  logic [7:0]       buf_wdata;
  logic             pkt_done;
  logic             pkt_ch;
  logic             pkt_timeout;
  logic [IDX_W-1:0] pkt_len;
`ifdef POLL_CHECKSUM_EN
  logic             pkt_cks_err;
`endif

  modport master (
    output tx_start, tx_data, buf_we, buf_addr, buf_wdata,
    output pkt_done, pkt_ch, pkt_timeout, pkt_len,
`ifdef POLL_CHECKSUM_EN
    output pkt_cks_err,
`endif
    input  tx_busy, rx_valid, rx_data
  );

  modport slave (
    input  tx_start, tx_data, buf_we, buf_addr, buf_wdata,
    input  pkt_done, pkt_ch, pkt_timeout, pkt_len,
`ifdef POLL_CHECKSUM_EN
    input  pkt_cks_err,
`endif
    output tx_busy, rx_valid, rx_data
  );

endinterface

// File: rtl/rs485_poll_sched_timer.sv
// Loadable down-counter with a registered expired flag (count == 0), shared by guard and RX timeout.
module poll_timer
  import rs485_poll_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [TO_W-1:0] val_i,
  output logic            expired_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            exp_q, exp_d;

  always_comb begin
    cnt_d = cnt_q;
    exp_d = exp_q;
    if (load_i) begin
      cnt_d = val_i;
      exp_d = (val_i == '0);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TO_W'(1);
      exp_d = (cnt_q == TO_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      exp_q <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      exp_q <= exp_d;
    end
  end

  assign expired_o = exp_q;

endmodule

// File: rtl/rs485_poll_sched.sv
// Polls RS485 ch0 then ch1 per poll_tick: request byte, turnaround, reply capture into the frame buffer.
// Optional POLL_CHECKSUM_EN: last reply byte is an XOR checksum, reported on pkt_cks_err.
module rs485_poll_sched
  import rs485_poll_pkg::*;
#(
  parameter int unsigned PKT_BYTES      = PKT_BYTES_DEF,
  parameter logic [7:0]  REQ_CODE       = REQ_CODE_DEF,
  parameter int unsigned GUARD_CYC      = 80,
  parameter int unsigned RX_TIMEOUT_CYC = 4000
) (
  input  logic                      clk80MHz,
  input  logic                      rst,
  input  logic                      poll_tick,
  rs485_poll_sched_if.master        bus,
  output logic                      UART_dTX1,
  output logic                      UART_dRX1,
  output logic                      UART_dTX2,
  output logic                      UART_dRX2,
  output logic                      tick_miss
);

  // Loading N-1 makes the flag rise exactly N cycles after the load.
  localparam logic [TO_W-1:0] GUARD_LD = TO_W'(GUARD_CYC - 1);
  localparam logic [TO_W-1:0] RXTO_LD  = TO_W'(RX_TIMEOUT_CYC - 1);

  state_t           state_q, state_d;
  logic             ch_q, ch_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             first_q, first_d;
  logic             busy_q;
  logic             tmr_load, tmr_exp;
  logic [TO_W-1:0]  tmr_val;

  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             buf_we_q, buf_we_d;
  logic [IDX_W:0]   buf_addr_q, buf_addr_d;
  logic [7:0]       buf_wdata_q, buf_wdata_d;
  logic             pkt_done_q, pkt_done_d;
  logic             pkt_ch_q, pkt_ch_d;
  logic [IDX_W-1:0] pkt_len_q, pkt_len_d;
  logic             pkt_to_q, pkt_to_d;
  logic             tick_miss_q, tick_miss_d;
  logic [1:0]       dtx_q, dtx_d, drx_q, drx_d;

  logic             rx_hit, last_byte, tx_phase;
  logic [7:0]       rx_byte;
`ifdef POLL_CHECKSUM_EN
  logic [7:0]       cks_q, cks_d;
  logic             cks_err_q, cks_err_d;
`endif

  assign rx_hit    = bus.rx_valid[ch_q];
  assign rx_byte   = ch_q ? bus.rx_data[15:8] : bus.rx_data[7:0];
  assign last_byte = (({1'b0, idx_q} + (IDX_W+1)'(1)) == (IDX_W+1)'(PKT_BYTES));

  poll_timer u_timer (
    .clk       (clk80MHz),
    .rst       (rst),
    .load_i    (tmr_load),
    .val_i     (tmr_val),
    .expired_o (tmr_exp)
  );

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    idx_d       = idx_q;
    first_d     = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    buf_we_d    = 1'b0;
    buf_addr_d  = buf_addr_q;
    buf_wdata_d = buf_wdata_q;
    pkt_done_d  = 1'b0;
    pkt_ch_d    = pkt_ch_q;
    pkt_len_d   = pkt_len_q;
    pkt_to_d    = pkt_to_q;
    tick_miss_d = poll_tick && (state_q != ST_IDLE);
`ifdef POLL_CHECKSUM_EN
    cks_d       = cks_q;
    cks_err_d   = cks_err_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (poll_tick) begin
          ch_d     = 1'b0;
          state_d  = ST_TX_SETUP;
          tmr_load = 1'b1;
          tmr_val  = GUARD_LD;
        end
      end
      ST_TX_SETUP: begin
        if (tmr_exp) begin
          tx_start_d = 1'b1;
          tx_data_d  = REQ_CODE;
          first_d    = 1'b1;
          state_d    = ST_TX_SEND;
        end
      end
      ST_TX_SEND: begin
        // The cycle carrying tx_start cannot show a genuine end of transmission.
        if (!first_q && busy_q && !bus.tx_busy) begin
          state_d  = ST_TX_HOLD;
          tmr_load = 1'b1;
          tmr_val  = GUARD_LD;
        end
      end
      ST_TX_HOLD: begin
        if (tmr_exp) begin
          state_d  = ST_RX_WAIT;
          idx_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = RXTO_LD;
`ifdef POLL_CHECKSUM_EN
          cks_d    = '0;
`endif
        end
      end
      ST_RX_WAIT: begin
        if (rx_hit) begin
          buf_we_d    = 1'b1;
          buf_addr_d  = {ch_q, idx_q};
          buf_wdata_d = rx_byte;
          idx_d       = (&idx_q) ? idx_q : idx_q + IDX_W'(1);
          tmr_load    = 1'b1;
          tmr_val     = RXTO_LD;
`ifdef POLL_CHECKSUM_EN
          if (last_byte) cks_err_d = (cks_q != rx_byte);
          else           cks_d     = cks_q ^ rx_byte;
`endif
          if (last_byte) begin
            state_d    = ST_DONE;
            pkt_done_d = 1'b1;
            pkt_ch_d   = ch_q;
            pkt_len_d  = idx_d;
            pkt_to_d   = 1'b0;
          end
        end else if (tmr_exp) begin
          state_d    = ST_DONE;
          pkt_done_d = 1'b1;
          pkt_ch_d   = ch_q;
          pkt_len_d  = idx_q;
          pkt_to_d   = 1'b1;
`ifdef POLL_CHECKSUM_EN
          cks_err_d  = 1'b0;
`endif
        end
      end
      ST_DONE: begin
        if (!ch_q) begin
          ch_d     = 1'b1;
          state_d  = ST_TX_SETUP;
          tmr_load = 1'b1;
          tmr_val  = GUARD_LD;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Direction lines follow the next state so driver/receiver switch in the same cycle.
    tx_phase = (state_d == ST_TX_SETUP) || (state_d == ST_TX_SEND) || (state_d == ST_TX_HOLD);
    dtx_d[0] = tx_phase && !ch_d;
    dtx_d[1] = tx_phase && ch_d;
    drx_d[0] = !((state_d == ST_RX_WAIT) && !ch_d);
    drx_d[1] = !((state_d == ST_RX_WAIT) && ch_d);
  end

  always_ff @(posedge clk80MHz or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ch_q        <= 1'b0;
      idx_q       <= '0;
      first_q     <= 1'b0;
      busy_q      <= 1'b0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      buf_we_q    <= 1'b0;
      buf_addr_q  <= '0;
      buf_wdata_q <= '0;
      pkt_done_q  <= 1'b0;
      pkt_ch_q    <= 1'b0;
      pkt_len_q   <= '0;
      pkt_to_q    <= 1'b0;
      tick_miss_q <= 1'b0;
      dtx_q       <= 2'b00;
      drx_q       <= 2'b11;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      idx_q       <= idx_d;
      first_q     <= first_d;
      busy_q      <= bus.tx_busy;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      buf_we_q    <= buf_we_d;
      buf_addr_q  <= buf_addr_d;
      buf_wdata_q <= buf_wdata_d;
      pkt_done_q  <= pkt_done_d;
      pkt_ch_q    <= pkt_ch_d;
      pkt_len_q   <= pkt_len_d;
      pkt_to_q    <= pkt_to_d;
      tick_miss_q <= tick_miss_d;
      dtx_q       <= dtx_d;
      drx_q       <= drx_d;
    end
  end

`ifdef POLL_CHECKSUM_EN
  always_ff @(posedge clk80MHz or posedge rst) begin
    if (rst) begin
      cks_q     <= '0;
      cks_err_q <= 1'b0;
    end else begin
      cks_q     <= cks_d;
      cks_err_q <= cks_err_d;
    end
  end

  assign bus.pkt_cks_err = cks_err_q;
`endif

  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.buf_we      = buf_we_q;
  assign bus.buf_addr    = buf_addr_q;
  assign bus.buf_wdata   = buf_wdata_q;
  assign bus.pkt_done    = pkt_done_q;
  assign bus.pkt_ch      = pkt_ch_q;
  assign bus.pkt_len     = pkt_len_q;
  assign bus.pkt_timeout = pkt_to_q;
  assign UART_dTX1       = dtx_q[0];
  assign UART_dTX2       = dtx_q[1];
  assign UART_dRX1       = drx_q[0];
  assign UART_dRX2       = drx_q[1];
  assign tick_miss       = tick_miss_q;

endmodule
